issue_check_n: RTL and testbench

ISSUE_CHECK_N -- requirements
Module: issue_check_n

---
 rtl/issue_check_n.sv | 171 +++++++++++++++++
 tb/tb_issue_check_n.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_check_n.sv
// In-order multi-slot issue stage: a circular instruction queue presents up to ISSUE_W
// of its oldest entries each cycle and issues them up to the first intra-group hazard.
module issue_check_n #(
   parameter int ISSUE_W   = 2,
   parameter int QDEPTH    = 8,
   parameter int PC_W      = 13,
   parameter int CHECK_WAW = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [32*ISSUE_W-1:0]      in_inst,
   input  logic [PC_W*ISSUE_W-1:0]    in_pc,
   output logic [32*ISSUE_W-1:0]      out_inst,
   output logic [PC_W*ISSUE_W-1:0]    out_pc,
   output logic [ISSUE_W-1:0]         out_valid,
   output logic [ISSUE_W-1:0]         branch_slotD,
   input  logic                       stall,
   input  logic                       flush,
   output logic [$clog2(QDEPTH):0]    count
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   function automatic logic writes_rd(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_OP) || (op == OP_LUI) ||
             (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP) ||
             (op == OP_BR) || (op == OP_JALR);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_STORE) || (op == OP_OP) || (op == OP_BR);
   endfunction

   // Anything that is not a plain ALU/memory/upper-immediate op serialises the group,
   // which covers branches, jumps, SYSTEM, FENCE and every undefined encoding.
   function automatic logic is_ctrl(input logic [6:0] op);
      return !((op == OP_LOAD) || (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP) ||
               (op == OP_LUI) || (op == OP_AUIPC));
   endfunction

   function automatic logic hazard(input logic [31:0] older, input logic [31:0] younger);
      logic [4:0] rd;
      logic       raw;
      logic       waw;
      logic       mem;
      rd  = older[11:7];
      raw = writes_rd(older[6:0]) && (rd != 5'd0) &&
            ((uses_rs1(younger[6:0]) && (younger[19:15] == rd)) ||
             (uses_rs2(younger[6:0]) && (younger[24:20] == rd)));
      waw = (CHECK_WAW != 0) && writes_rd(older[6:0]) && writes_rd(younger[6:0]) &&
            (rd != 5'd0) && (younger[11:7] == rd);
      mem = (older[6:0] == OP_STORE) &&
            ((younger[6:0] == OP_STORE) || (younger[6:0] == OP_LOAD));
      if ((older == 32'd0) || (younger == 32'd0)) begin
         return 1'b0;
      end
      return raw || waw || mem || is_ctrl(older[6:0]);
   endfunction

   logic [31:0]      inst_q [QDEPTH];
   logic [PC_W-1:0]  pc_q   [QDEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic [31:0]      head_inst [ISSUE_W];
   logic [PC_W-1:0]  head_pc   [ISSUE_W];
   logic [PTR_W-1:0] enq_off   [ISSUE_W];
   logic [CNT_W-1:0] avail;
   logic [CNT_W-1:0] issue_k;
   logic [CNT_W-1:0] enq_n;
   logic [ISSUE_W-1:0] issue_ctrl;
   logic             accept;

   always_comb begin
      avail = (count < CNT_W'(ISSUE_W)) ? count : CNT_W'(ISSUE_W);
      for (int j = 0; j < ISSUE_W; j++) begin
         head_inst[j] = inst_q[rd_ptr + PTR_W'(j)];
         head_pc[j]   = pc_q[rd_ptr + PTR_W'(j)];
      end
      // Scan youngest to oldest so the lowest hazarding slot is the one that sticks.
      issue_k = avail;
      for (int j = ISSUE_W - 1; j >= 1; j--) begin
         for (int i = 0; i < j; i++) begin
            if ((CNT_W'(j) < avail) && hazard(head_inst[i], head_inst[j])) begin
               issue_k = CNT_W'(j);
            end
         end
      end
   end

   always_comb begin
      out_inst   = '0;
      out_pc     = '0;
      out_valid  = '0;
      issue_ctrl = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
         if (CNT_W'(j) < issue_k) begin
            out_valid[j]              = 1'b1;
            out_inst[32*j +: 32]      = head_inst[j];
            out_pc[PC_W*j +: PC_W]    = head_pc[j];
            issue_ctrl[j]             = is_ctrl(head_inst[j][6:0]) && (head_inst[j] != 32'd0);
         end
      end
   end

   always_comb begin
      enq_n = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
         enq_off[j] = PTR_W'(enq_n);
         if (in_inst[32*j +: 32] != 32'd0) begin
            enq_n = enq_n + CNT_W'(1);
         end
      end
   end

   assign in_ready = ((CNT_W'(QDEPTH) - count) >= enq_n) && !flush;
   assign accept   = in_valid && in_ready;

   // Bubbles are squeezed out here, so every stored entry is a real instruction.
   always_ff @(posedge CLK) begin
      if (accept) begin
         for (int j = 0; j < ISSUE_W; j++) begin
            if (in_inst[32*j +: 32] != 32'd0) begin
               inst_q[wr_ptr + enq_off[j]] <= in_inst[32*j +: 32];
               pc_q[wr_ptr + enq_off[j]]   <= in_pc[PC_W*j +: PC_W];
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         branch_slotD <= '0;
      end else if (flush) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         branch_slotD <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
         end
         if (!stall) begin
            rd_ptr       <= rd_ptr + PTR_W'(issue_k);
            branch_slotD <= issue_ctrl;
         end
         count <= count - (stall ? CNT_W'(0) : issue_k) + (accept ? enq_n : CNT_W'(0));
      end
   end

endmodule

// File: tb/tb_issue_check_n.sv
// Bench for issue_check_n: two instances (2-wide/8-deep and 4-wide/16-deep) driven by
// directed groups and random traffic, compared each cycle against a queue-based model.
module tb_issue_check_n;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic         iv2, st2, fl2, rdy2;
   logic [63:0]  ii2, oi2;
   logic [25:0]  ip2, op2;
   logic [1:0]   ov2, bs2;
   logic [3:0]   cnt2;

   logic         iv4, st4, fl4, rdy4;
   logic [127:0] ii4, oi4;
   logic [51:0]  ip4, op4;
   logic [3:0]   ov4, bs4;
   logic [4:0]   cnt4;

   issue_check_n #(.ISSUE_W(2), .QDEPTH(8), .PC_W(13), .CHECK_WAW(1)) dut2 (
      .CLK(CLK), .RST(RST), .in_valid(iv2), .in_ready(rdy2), .in_inst(ii2), .in_pc(ip2),
      .out_inst(oi2), .out_pc(op2), .out_valid(ov2), .branch_slotD(bs2),
      .stall(st2), .flush(fl2), .count(cnt2));

   issue_check_n #(.ISSUE_W(4), .QDEPTH(16), .PC_W(13), .CHECK_WAW(1)) dut4 (
      .CLK(CLK), .RST(RST), .in_valid(iv4), .in_ready(rdy4), .in_inst(ii4), .in_pc(ip4),
      .out_inst(oi4), .out_pc(op4), .out_valid(ov4), .branch_slotD(bs4),
      .stall(st4), .flush(fl4), .count(cnt4));

   int n_assert = 0;
   int n_fail   = 0;

   // model queues hold {pc, inst}, oldest first
   logic [44:0] mq2[$];
   logic [44:0] mq4[$];
   logic [3:0]  bd2, bd4;

   typedef struct packed {
      logic wr; logic r1; logic r2; logic ctrl; logic st; logic ld;
   } cls_t;

   function automatic cls_t classify(input logic [31:0] w);
      cls_t c;
      c = '0;
      case (w[6:0])
         7'h03: begin c.wr = 1'b1; c.r1 = 1'b1; c.ld = 1'b1; end
         7'h23: begin c.r1 = 1'b1; c.r2 = 1'b1; c.st = 1'b1; end
         7'h13: begin c.wr = 1'b1; c.r1 = 1'b1; end
         7'h33: begin c.wr = 1'b1; c.r1 = 1'b1; c.r2 = 1'b1; end
         7'h37, 7'h17: c.wr = 1'b1;
         7'h6F: begin c.wr = 1'b1; c.ctrl = 1'b1; end
         7'h67: begin c.wr = 1'b1; c.r1 = 1'b1; c.ctrl = 1'b1; end
         7'h63: begin c.r1 = 1'b1; c.r2 = 1'b1; c.ctrl = 1'b1; end
         default: c.ctrl = 1'b1;
      endcase
      return c;
   endfunction

   function automatic bit haz(input logic [31:0] a, input logic [31:0] b);
      cls_t ca, cb;
      logic [4:0] rd;
      if (a == 32'd0 || b == 32'd0) return 1'b0;
      ca = classify(a);
      cb = classify(b);
      rd = a[11:7];
      if (ca.ctrl) return 1'b1;
      if (ca.st && (cb.st || cb.ld)) return 1'b1;
      if (ca.wr && rd != 5'd0) begin
         if (cb.r1 && b[19:15] == rd) return 1'b1;
         if (cb.r2 && b[24:20] == rd) return 1'b1;
         if (cb.wr && b[11:7] == rd) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int first_hazard(input logic [44:0] h[4], input int n);
      for (int j = 1; j < n; j++)
         for (int i = 0; i < j; i++)
            if (haz(h[i][31:0], h[j][31:0])) return j;
      return n;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] op;
      if ($urandom_range(0, 4) == 0) return 32'd0;
      case ($urandom_range(0, 11))
         0: op = 7'h03;  1: op = 7'h23;  2: op = 7'h13;  3: op = 7'h33;
         4: op = 7'h37;  5: op = 7'h17;  6: op = 7'h6F;  7: op = 7'h67;
         8: op = 7'h63;  9: op = 7'h73;  10: op = 7'h0F; default: op = 7'h2B;
      endcase
      return {7'($urandom_range(0, 127)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), op};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string p, input int w, input int qd, input logic [44:0] h[4],
                            input int len, input logic [127:0] in_i, input logic fl,
                            input logic [3:0] bd, input logic [127:0] o_i, input logic [51:0] o_p,
                            input logic [3:0] o_v, input logic [3:0] o_b, input logic [4:0] o_c,
                            input logic o_r, output int k, output logic [3:0] ec, output logic rdy);
      int n, nb;
      logic [127:0] ei;
      logic [51:0]  ep;
      logic [3:0]   ev;
      cls_t c;
      n  = (len < w) ? len : w;
      k  = first_hazard(h, n);
      ei = '0; ep = '0; ev = '0; ec = '0;
      for (int j = 0; j < k; j++) begin
         ei[32*j +: 32] = h[j][31:0];
         ep[13*j +: 13] = h[j][44:32];
         ev[j] = 1'b1;
         c = classify(h[j][31:0]);
         ec[j] = c.ctrl;
      end
      nb = 0;
      for (int j = 0; j < w; j++) if (in_i[32*j +: 32] != 32'd0) nb++;
      rdy = ((qd - len) >= nb) && !fl;
      chk({p, "_count"},  128'(o_c), 128'(len));
      chk({p, "_valid"},  128'(o_v), 128'(ev));
      chk({p, "_inst"},   o_i, ei);
      chk({p, "_pc"},     128'(o_p), 128'(ep));
      chk({p, "_ready"},  128'(o_r), 128'(rdy));
      chk({p, "_brslot"}, 128'(o_b), 128'(bd));
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      int k2, k4;
      logic [3:0] ec2, ec4;
      logic r2, r4;
      logic [44:0] h[4];
      #1;
      for (int j = 0; j < 4; j++) h[j] = (j < mq2.size()) ? mq2[j] : 45'd0;
      check_dut("w2", 2, 8, h, mq2.size(), 128'(ii2), fl2, bd2, 128'(oi2), 52'(op2),
                4'(ov2), 4'(bs2), 5'(cnt2), rdy2, k2, ec2, r2);
      for (int j = 0; j < 4; j++) h[j] = (j < mq4.size()) ? mq4[j] : 45'd0;
      check_dut("w4", 4, 16, h, mq4.size(), ii4, fl4, bd4, oi4, op4,
                ov4, bs4, cnt4, rdy4, k4, ec4, r4);
      @(posedge CLK);
      if (fl2) begin
         mq2.delete(); bd2 = '0;
      end else begin
         if (!st2) begin
            for (int j = 0; j < k2; j++) void'(mq2.pop_front());
            bd2 = ec2;
         end
         if (iv2 && r2)
            for (int j = 0; j < 2; j++)
               if (ii2[32*j +: 32] != 32'd0) mq2.push_back({ip2[13*j +: 13], ii2[32*j +: 32]});
      end
      if (fl4) begin
         mq4.delete(); bd4 = '0;
      end else begin
         if (!st4) begin
            for (int j = 0; j < k4; j++) void'(mq4.pop_front());
            bd4 = ec4;
         end
         if (iv4 && r4)
            for (int j = 0; j < 4; j++)
               if (ii4[32*j +: 32] != 32'd0) mq4.push_back({ip4[13*j +: 13], ii4[32*j +: 32]});
      end
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1;
      iv2 = 1'b0; st2 = 1'b0; fl2 = 1'b0; ii2 = '0; ip2 = '0;
      iv4 = 1'b0; st4 = 1'b0; fl4 = 1'b0; ii4 = '0; ip4 = '0;
      bd2 = '0; bd4 = '0;
      @(posedge CLK);
      #1;
      chk("rst_count2", 128'(cnt2), 128'(0));
      chk("rst_valid2", 128'(ov2), 128'(0));
      chk("rst_ready2", 128'(rdy2), 128'(1));
      chk("rst_br2",    128'(bs2), 128'(0));
      chk("rst_count4", 128'(cnt4), 128'(0));
      @(negedge CLK);
      RST = 1'b0;

      // RAW inside a pair: addi x1 then add x2,x1,x1
      ii2 = {32'h00108133, 32'h00100093}; ip2 = {13'd4, 13'd0}; iv2 = 1'b1;
      step();
      chk("r027_c1_valid", 128'(ov2), 128'(2'b01));
      iv2 = 1'b0;
      step();
      chk("r027_c2_inst",  128'(oi2[31:0]), 128'(32'h00108133));
      chk("r027_c2_valid", 128'(ov2), 128'(2'b01));
      step();

      // store followed by load splits; independent addi+load pairs
      ii2 = {32'h00002183, 32'h00102023}; ip2 = {13'd12, 13'd8}; iv2 = 1'b1;
      step();
      chk("r028_split_c1", 128'(ov2), 128'(2'b01));
      iv2 = 1'b0;
      step();
      chk("r028_split_c2", 128'(oi2[31:0]), 128'(32'h00002183));
      step();
      ii2 = {32'h00002183, 32'h00100093}; ip2 = {13'd20, 13'd16}; iv2 = 1'b1;
      step();
      chk("r028_pair", 128'(ov2), 128'(2'b11));
      iv2 = 1'b0;
      step();

      // 4-wide: branch serialises, then RAW, then a clean pair
      ii4 = {32'h00002183, 32'h00108133, 32'h00100093, 32'h00000463};
      ip4 = {13'd12, 13'd8, 13'd4, 13'd0}; iv4 = 1'b1;
      step();
      chk("r029_c1", 128'(ov4), 128'(4'b0001));
      iv4 = 1'b0;
      step();
      chk("r029_br", 128'(bs4), 128'(4'b0001));
      chk("r029_c2", 128'(ov4), 128'(4'b0001));
      step();
      chk("r029_c3", 128'(ov4), 128'(4'b0011));
      step();

      // fill under stall until full, then drain
      ii2 = {32'h00100193, 32'h00100113}; ip2 = {13'd104, 13'd100}; iv2 = 1'b1; st2 = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("r030_full",  128'(cnt2), 128'(8));
      chk("r030_ready", 128'(rdy2), 128'(0));
      st2 = 1'b0; iv2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("r030_drain", 128'(cnt2), 128'(6 - 2*i));
      end

      // flush beats stall and drops the same-cycle group
      ii2 = {32'h00100093, 32'h0000006F}; ip2 = {13'd204, 13'd200}; iv2 = 1'b1;
      step();
      iv2 = 1'b0;
      step();
      chk("r031_br", 128'(bs2), 128'(2'b01));
      st2 = 1'b1; iv2 = 1'b1; ii2 = {32'h00100193, 32'h00100113};
      step();
      step();
      ii2 = {32'h00000000, 32'h00100113};
      step();
      chk("r031_pre",   128'(cnt2), 128'(6));
      chk("r031_brhold", 128'(bs2), 128'(2'b01));
      fl2 = 1'b1; ii2 = {32'h00100193, 32'h00100113};
      step();
      chk("r031_count",  128'(cnt2), 128'(0));
      chk("r031_br_clr", 128'(bs2), 128'(0));
      chk("r031_drop",   128'(ov2), 128'(0));
      fl2 = 1'b0; st2 = 1'b0; iv2 = 1'b0;
      step();

      // asynchronous reset in the middle of a split group
      ii2 = {32'h00002183, 32'h00102023}; ip2 = {13'd304, 13'd300}; iv2 = 1'b1;
      step();
      iv2 = 1'b0;
      step();
      chk("r032_pre", 128'(cnt2), 128'(1));
      RST = 1'b1;
      #1;
      chk("r032_count", 128'(cnt2), 128'(0));
      chk("r032_valid", 128'(ov2), 128'(0));
      chk("r032_inst",  128'(oi2), 128'(0));
      mq2.delete(); mq4.delete(); bd2 = '0; bd4 = '0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      for (int c = 0; c < 400; c++) begin
         iv2 = ($urandom_range(0, 9) < 6);
         st2 = ($urandom_range(0, 3) == 0);
         fl2 = ($urandom_range(0, 19) == 0);
         ii2 = {rand_inst(), rand_inst()};
         ip2 = 26'($urandom);
         iv4 = ($urandom_range(0, 9) < 6);
         st4 = ($urandom_range(0, 3) == 0);
         fl4 = ($urandom_range(0, 19) == 0);
         ii4 = {rand_inst(), rand_inst(), rand_inst(), rand_inst()};
         ip4 = {20'($urandom), 32'($urandom)};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
